neuron_mac_fix: RTL and testbench
=================================

// Module: neuron_mac_fix
// PURPOSE
//  Sequential fixed-point neuron: streams N_INPUTS (x,w) pairs, one per accepted beat.
//  Accumulates bias + sum(x*w) in a wide accumulator, then saturates to WIDTH.
//  Sits directly upstream of scaler_mul_fix and feeds its 'in' port (out_data -> in).
//  Saturation range is symmetric, the same as scaler_mul_fix: [-(2^(W-1)-1), 2^(W-1)-1].
// PARAMETERS
//  WIDTH     16  data width of x, w, bias, out_data (signed, two's complement)
//  FRAC      8   fractional bits of the Q format (same for all operands)
//  N_INPUTS  784 expected beats per neuron; used only for the length check
//  ACC_W     2*WIDTH+$clog2(N_INPUTS)  accumulator width; no internal overflow by construction
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  bias      in   WIDTH  neuron bias; sampled on the first accepted beat of a neuron
//  in_valid  in   1      beat valid
//  in_ready  out  1      block can accept a beat
//  in_x      in   WIDTH  activation
//  in_w      in   WIDTH  weight
//  in_last   in   1      final beat of this neuron
//  out_valid out  1      out_data holds a result
//  out_ready in   1      consumer accepts the result
//  out_data  out  WIDTH  saturated neuron result (feeds scaler_mul_fix.in)
//  len_err   out  1      sticky: a neuron ended with beat count != N_INPUTS
//  busy      out  1      state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert inside clk domain):
//   state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, len_err=0, busy=0.
//  A beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
//  Product: p = (x*w) as 2*WIDTH signed, then arithmetic >>> FRAC (truncate toward -inf).
//   Sign-extend p to ACC_W.
//  FSM:
//   IDLE : in_ready=1. On beat: acc<=sext(bias<<<FRAC>>>FRAC)+p, i.e. sext(bias)+p; cnt<=1.
//          in_last ? ->OUT : ->ACCUM.
//   ACCUM: in_ready=1. On beat: acc<=acc+p; cnt<=cnt+1; in_last ? ->OUT : stay.
//   OUT  : in_ready=0; out_valid=1. out_data is registered on the OUT entry edge as sat(acc).
//          On out_ready: ->IDLE, out_valid<=0.
//  sat(acc): if acc>2^(W-1)-1 then 0x7FFF..; if acc<-(2^(W-1)-1) then 0x80..01; else acc[W-1:0].
//  Latency: out_valid rises 1 cycle after the in_last beat is accepted.
//  Throughput: 1 beat/clk. One bubble cycle per neuron minimum (OUT state, in_ready=0).
//  Backpressure: out_data and out_valid are held stable while out_ready=0; no beat is accepted.
//  No beat with in_valid=0 ever changes acc or cnt. in_x, in_w and in_last are don't-care then.
//  Length check: on the in_last beat, if cnt_next != N_INPUTS then len_err<=1.
//   The result is still produced. len_err clears only on reset.
//  cnt saturates at 2^$clog2(N_INPUTS+1)-1; it does not wrap.
//   Beats beyond that count still accumulate.
//  A single-beat neuron (in_last on the first beat) is legal: IDLE->OUT directly.
//  Reset mid-neuron: the partial acc is discarded and the FSM returns to IDLE.
//   No out_valid is produced for that neuron.
// CONFIGURATION
//  NEURON_MAC_RELU_EN defined:
//   out_data = (acc<0) ? 0 : sat(acc). Negative results never reach the scaler.
//  NEURON_MAC_RELU_EN undefined:
//   out_data = sat(acc), signed. Timing and handshake are identical in both builds.
// STRUCTURE
//  Package fix_pkg:
//   state typedef enum {IDLE, ACCUM, OUT}.
//   Functions fix_max_pos(W)=2^(W-1)-1 and fix_max_neg(W)=-(2^(W-1)-1).
//   Function sat_to_width(acc).
//   fix_pkg is shared with scaler_mul_fix.
//  Sub-module fix_mul_q: combinational x*w with >>>FRAC; outputs the 2*WIDTH product.
//  Top level: FSM, counter, accumulator, output register.
// TESTING (WIDTH=16, FRAC=8, N_INPUTS=4 for bench)
//  1. bias=0x0000; beats (0x0100,0x0200)x4, last on beat 4
//     -> out_data=0x0800 one cycle after last; len_err=0.
//  2. bias=0; 4 beats of (0x7F00,0x7F00)
//     -> out_data=0x7FFF (positive saturation).
//     Same beats with w=0x8100 -> 0x8001 (0x0000 with RELU_EN).
//  3. out_ready held 0 for 5 cycles after out_valid
//     -> out_data stable, in_ready=0, in_valid beats not consumed. out_ready=1 -> IDLE next cycle.
//  4. in_last on beat 2 -> result = bias + 2 products, len_err=1, and len_err stays 1 after the next neuron.
//  5. rst_n pulsed low after beat 2 -> all outputs return to reset values asynchronously.
//     The next 4-beat neuron gives a fresh result with no residue.
//  6. in_valid toggled randomly on every beat -> result matches the gap-free run of scenario 1.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared fixed-point helpers for neuron_mac_fix and scaler_mul_fix: FSM state
// type and the symmetric saturation used by both blocks.
// Values are carried as 64-bit signed, so accumulators up to 64 bits are supported.
package fix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Largest positive value of a W-bit signed result: 2^(W-1)-1
    function automatic logic signed [63:0] fix_max_pos(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value allowed; symmetric, so the two's complement minimum is never produced
    function automatic logic signed [63:0] fix_max_neg(input int w);
        return -fix_max_pos(w);
    endfunction

    // Clamp a wide signed value into the symmetric W-bit range
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] acc,
                                                        input int w);
        if (acc > fix_max_pos(w))
            return fix_max_pos(w);
        else if (acc < fix_max_neg(w))
            return fix_max_neg(w);
        else
            return acc;
    endfunction

endpackage

// File: rtl/fix_mul_q.sv
// Combinational Q-format multiply: full signed product, then arithmetic shift
// right by FRAC, which truncates toward minus infinity.
module fix_mul_q #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic        [WIDTH-1:0]   x,
    input  logic        [WIDTH-1:0]   w,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] prod;

    // Both operands sign-extend to the 2*WIDTH result, so the product never overflows
    always_comb begin
        prod = $signed(x) * $signed(w);
        p    = prod >>> FRAC;
    end

endmodule

// File: rtl/neuron_mac_fix.sv
// Sequential fixed-point neuron: bias + sum(x*w) over a stream of beats,
// saturated to WIDTH and held until the consumer takes it.
// Optional build macro NEURON_MAC_RELU_EN: negative results are output as zero.
module neuron_mac_fix #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int N_INPUTS = 784,
    parameter int ACC_W    = 2*WIDTH + $clog2(N_INPUTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             len_err,
    output logic             busy
);
    import fix_pkg::*;

    localparam int               CNT_W   = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(N_INPUTS);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_next;
    logic signed [ACC_W-1:0]   p_ext, bias_ext;
    logic        [CNT_W-1:0]   cnt_q, cnt_d, cnt_next;
    logic        [WIDTH-1:0]   out_data_q, out_data_d, result;
    logic                      len_err_q, len_err_d;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [63:0]        acc64, sat64;
    logic                      beat;
    logic                      sat_unused;

    fix_mul_q #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .x (in_x),
        .w (in_w),
        .p (prod)
    );

    assign in_ready  = (state_q != OUT);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign len_err   = len_err_q;
    assign beat      = in_valid && in_ready;

    // Next accumulator/count for the current beat and the saturated result it would give
    always_comb begin
        p_ext    = ACC_W'(prod);
        bias_ext = ACC_W'($signed(bias));
        if (state_q == IDLE) begin
            acc_next = bias_ext + p_ext;
            cnt_next = CNT_W'(1);
        end else begin
            acc_next = acc_q + p_ext;
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        acc64      = 64'(acc_next);
        sat64      = sat_to_width(acc64, WIDTH);
        sat_unused = ^sat64[63:WIDTH];
`ifdef NEURON_MAC_RELU_EN
        result = acc_next[ACC_W-1] ? '0 : sat64[WIDTH-1:0];
`else
        result = sat64[WIDTH-1:0];
`endif
    end

    // FSM: accumulate beats until in_last, then hold the result until it is taken
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        len_err_d  = len_err_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    if (in_last) begin
                        state_d    = OUT;
                        out_data_d = result;
                        if (cnt_next != CNT_EXP)
                            len_err_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any partial neuron
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_fix.sv
// Self-checking bench for neuron_mac_fix (WIDTH=16, FRAC=8, N_INPUTS=4).
// Honours NEURON_MAC_RELU_EN when the same macro is defined for the bench.
module tb_neuron_mac_fix;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bias;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_w;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         len_err;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] bx [16];
    logic [W-1:0] bw [16];

    neuron_mac_fix #(.WIDTH(16), .FRAC(8), .N_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .len_err   (len_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] x;
        logic [W-1:0] w;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef NEURON_MAC_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: plain integer arithmetic over the stored beats
    function automatic logic [W-1:0] model(input logic [W-1:0] b, input int n);
        longint acc;
        longint prod;
        logic [63:0] r;
        acc = longint'($signed(b));
        for (int i = 0; i < n; i++) begin
            prod = longint'($signed(bx[i])) * longint'($signed(bw[i]));
            acc  = acc + (prod >>> 8);
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32767) acc = -32767;
        r = 64'(acc);
        return relu(r[W-1:0]);
    endfunction

    // Stream n beats from bx/bw; optional idle gaps with garbage payload
    task automatic run_neuron(input logic [W-1:0] b, input int n, input bit gaps,
                              output logic [W-1:0] got);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_x     = W'($urandom);
                    in_w     = W'($urandom);
                    in_last  = 1'($urandom);
                    bias     = W'($urandom);
                end
            end
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'd1);
            chk("out_valid_pre", 32'(out_valid), 32'd0);
            chk("busy", 32'(busy), (i == 0) ? 32'd0 : 32'd1);
            in_valid = 1'b1;
            in_x     = bx[i];
            in_w     = bw[i];
            in_last  = (i == n - 1);
            bias     = (i == 0) ? b : W'($urandom);
        end
        @(posedge clk);
        #1;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        got = out_data;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Hold out_ready low for 'hold' cycles while offering beats, then take the result
    task automatic take_result(input int hold, input logic [W-1:0] exp);
        for (int c = 0; c < hold; c++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'(exp));
            in_valid = 1'b1;
            in_x     = W'($urandom);
            in_w     = W'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t         tbl [10];
    logic [W-1:0] got;
    logic [W-1:0] exp;
    bit           err_model;
    int           n;

    initial begin
        tbl[0] = '{16'h0000, 16'h0100, 16'h0200, relu(16'h0800)};
        tbl[1] = '{16'h0000, 16'h7F00, 16'h7F00, relu(16'h7FFF)};
        tbl[2] = '{16'h0000, 16'h7F00, 16'h8100, relu(16'h8001)};
        tbl[3] = '{16'h0100, 16'h0180, 16'hFF00, relu(16'hFB00)};
        tbl[4] = '{16'h0000, 16'hFFFF, 16'h0001, relu(16'hFFFC)};
        tbl[5] = '{16'h0000, 16'h0001, 16'h0001, relu(16'h0000)};
        tbl[6] = '{16'h7FFF, 16'h0000, 16'h0000, relu(16'h7FFF)};
        tbl[7] = '{16'h8000, 16'h0000, 16'h0000, relu(16'h8001)};
        tbl[8] = '{16'h0000, 16'h0100, 16'h0080, relu(16'h0200)};
        tbl[9] = '{16'h7F00, 16'h0100, 16'h0040, relu(16'h7FFF)};

        rst_n = 1'b0; bias = '0; in_valid = 1'b0; in_x = '0; in_w = '0;
        in_last = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: four identical beats per vector, no gaps
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) begin
                bx[i] = tbl[v].x;
                bw[i] = tbl[v].w;
            end
            run_neuron(tbl[v].b, N, 1'b0, got);
            chk($sformatf("tbl%0d_data", v), 32'(got), 32'(tbl[v].exp));
            chk($sformatf("tbl%0d_len_err", v), 32'(len_err), 32'd0);
            take_result(0, tbl[v].exp);
        end

        // Backpressure: five stalled cycles with beats offered, then release
        for (int i = 0; i < N; i++) begin bx[i] = 16'h0100; bw[i] = 16'h0200; end
        run_neuron(16'h0000, N, 1'b0, got);
        chk("bp_data", 32'(got), 32'(relu(16'h0800)));
        take_result(5, got);
        run_neuron(16'h0000, N, 1'b0, got);
        chk("bp_next_data", 32'(got), 32'(relu(16'h0800)));
        take_result(0, got);

        // Short neuron: in_last on beat 2
        for (int i = 0; i < 2; i++) begin bx[i] = 16'h0200; bw[i] = 16'h0300; end
        run_neuron(16'h0100, 2, 1'b0, got);
        chk("short_data", 32'(got), 32'(relu(16'h0D00)));
        chk("short_len_err", 32'(len_err), 32'd1);
        take_result(1, got);
        for (int i = 0; i < N; i++) begin bx[i] = 16'h0100; bw[i] = 16'h0200; end
        run_neuron(16'h0000, N, 1'b0, got);
        chk("sticky_data", 32'(got), 32'(relu(16'h0800)));
        chk("sticky_len_err", 32'(len_err), 32'd1);
        take_result(0, got);

        // Reset mid-neuron after two beats, asynchronously between edges
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = 16'h7F00; in_w = 16'h7F00; in_last = 1'b0; bias = 16'h7FFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_len_err", 32'(len_err), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin bx[i] = 16'h0100; bw[i] = 16'h0200; end
        run_neuron(16'h0000, N, 1'b0, got);
        chk("post_rst_data", 32'(got), 32'(relu(16'h0800)));
        chk("post_rst_len_err", 32'(len_err), 32'd0);
        take_result(0, got);

        // Gapped version of the first vector
        run_neuron(16'h0000, N, 1'b1, got);
        chk("gap_data", 32'(got), 32'(relu(16'h0800)));
        take_result(2, got);

        // Random neurons against the reference model, including odd lengths
        err_model = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : N;
            for (int i = 0; i < n; i++) begin
                if (k % 2 == 0) begin
                    bx[i] = W'($urandom);
                    bw[i] = W'($urandom);
                end else begin
                    bx[i] = W'($urandom_range(0, 16'h0600)) - 16'h0300;
                    bw[i] = W'($urandom_range(0, 16'h0600)) - 16'h0300;
                end
            end
            exp = W'($urandom);
            run_neuron(exp, n, 1'($urandom), got);
            exp = model(exp, n);
            if (n != N) err_model = 1'b1;
            chk($sformatf("rnd%0d_n%0d_data", k, n), 32'(got), 32'(exp));
            chk($sformatf("rnd%0d_len_err", k), 32'(len_err), 32'(err_model));
            take_result($urandom_range(0, 3), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
